// File: rtl/fpu_addsub_param.sv
// Multi-cycle add/subtract for a {sign, exp[EXP_W], frac[FRAC_W]} float with RNE rounding.
// Define FPU_LZC_NORM_EN for single-cycle leading-zero-count normalisation.
module fpu_addsub_param #(
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned FRAC_W = 25,
  localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out,
  output logic         busy
);

  localparam int unsigned SigW = FRAC_W + 1;
  localparam int unsigned ExtW = SigW + 3;
  localparam int unsigned MagW = ExtW + 1;
  localparam logic [EXP_W-1:0] ExpMax = '1;
  localparam logic [EXP_W-1:0] ExpOne = 1;
`ifdef FPU_LZC_NORM_EN
  localparam int unsigned LzW = $clog2(ExtW) + 1;
`endif

  typedef enum logic [2:0] {
    StIdle, StAlign, StOperate, StNormalize, StRound, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic              sign_l_q, sign_l_d, sign_s_q, sign_s_d, sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [ExtW-1:0]   sig_l_q, sig_l_d, sig_s_q, sig_s_d;
  logic [MagW-1:0]   mag_q, mag_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;
  logic [W-1:0]      data_q, data_d;
  logic [3:0]        status_q, status_d;

  logic [EXP_W-1:0]  ea, eb, exp_big, exp_small, diff;
  logic [SigW-1:0]   sig_a, sig_b, sig_big, sig_small;
  logic              a_big;
  logic [ExtW-1:0]   ext_small, shifted;
  logic [MagW-1:0]   op_mag;
  logic              op_sign;
  logic              g, r, s, lsb, inc, inexact;
  logic [SigW:0]     rnd;
`ifdef FPU_LZC_NORM_EN
  logic [LzW-1:0]    lz;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_l_d = sign_l_q;
    sign_s_d = sign_s_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_l_d  = sig_l_q;
    sig_s_d  = sig_s_q;
    mag_d    = mag_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    zero_d   = zero_q;
    data_d   = data_q;
    status_d = status_q;

    ea    = a_q[W-2 -: EXP_W];
    eb    = b_q[W-2 -: EXP_W];
    sig_a = (ea == '0 && a_q[FRAC_W-1:0] == '0) ? '0 : {1'b1, a_q[FRAC_W-1:0]};
    sig_b = (eb == '0 && b_q[FRAC_W-1:0] == '0) ? '0 : {1'b1, b_q[FRAC_W-1:0]};
    a_big     = (ea >= eb);
    exp_big   = a_big ? ea : eb;
    exp_small = a_big ? eb : ea;
    sig_big   = a_big ? sig_a : sig_b;
    sig_small = a_big ? sig_b : sig_a;
    diff      = exp_big - exp_small;
    ext_small = {sig_small, 3'b000};
    // Bits pushed past the sticky position collapse into bit 0.
    if (32'(diff) >= ExtW) begin
      shifted    = '0;
      shifted[0] = |sig_small;
    end else begin
      shifted    = ext_small >> diff;
      shifted[0] = shifted[0] | (|(ext_small & ~({ExtW{1'b1}} << diff)));
    end

    if (sign_l_q == sign_s_q) begin
      op_mag  = {1'b0, sig_l_q} + {1'b0, sig_s_q};
      op_sign = sign_l_q;
    end else if (sig_l_q >= sig_s_q) begin
      op_mag  = {1'b0, sig_l_q - sig_s_q};
      op_sign = sign_l_q;
    end else begin
      op_mag  = {1'b0, sig_s_q - sig_l_q};
      op_sign = sign_s_q;
    end
    if (op_mag == '0) op_sign = 1'b0;

    g       = mag_q[2];
    r       = mag_q[1];
    s       = mag_q[0];
    lsb     = mag_q[3];
    inc     = g & (r | s | lsb);
    inexact = g | r | s;
    rnd     = {1'b0, mag_q[ExtW-1:3]} + (SigW+1)'(inc);

`ifdef FPU_LZC_NORM_EN
    lz = '0;
    for (int i = 0; i < ExtW; i++) begin
      if (mag_q[i]) lz = LzW'(ExtW - 1 - i);
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = {op_b[W-1] ^ sub, op_b[W-2:0]};
          state_d = StAlign;
        end
      end
      StAlign: begin
        sign_l_d = a_big ? a_q[W-1] : b_q[W-1];
        sign_s_d = a_big ? b_q[W-1] : a_q[W-1];
        exp_d    = exp_big;
        sig_l_d  = {sig_big, 3'b000};
        sig_s_d  = shifted;
        state_d  = StOperate;
      end
      StOperate: begin
        mag_d   = op_mag;
        sign_d  = op_sign;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        zero_d  = 1'b0;
        state_d = StNormalize;
      end
      StNormalize: begin
`ifdef FPU_LZC_NORM_EN
        state_d = StRound;
        if (mag_q == '0) begin
          zero_d = 1'b1;
        end else if (mag_q[MagW-1]) begin
          if (exp_q == ExpMax) begin
            ovf_d = 1'b1;
          end else begin
            mag_d = {1'b0, mag_q[MagW-1:2], mag_q[1] | mag_q[0]};
            exp_d = exp_q + ExpOne;
          end
        end else if (32'(lz) <= 32'(exp_q)) begin
          mag_d = mag_q << lz;
          exp_d = exp_q - EXP_W'(lz);
        end else begin
          unf_d = 1'b1;
        end
`else
        if (mag_q == '0) begin
          zero_d  = 1'b1;
          state_d = StRound;
        end else if (mag_q[MagW-1]) begin
          if (exp_q == ExpMax) begin
            ovf_d   = 1'b1;
            state_d = StRound;
          end else begin
            mag_d = {1'b0, mag_q[MagW-1:2], mag_q[1] | mag_q[0]};
            exp_d = exp_q + ExpOne;
          end
        end else if (!mag_q[MagW-2]) begin
          if (exp_q == '0) begin
            unf_d   = 1'b1;
            state_d = StRound;
          end else begin
            mag_d = mag_q << 1;
            exp_d = exp_q - ExpOne;
          end
        end else begin
          state_d = StRound;
        end
`endif
      end
      StRound: begin
        state_d = StDone;
        if (ovf_q || (!unf_q && !zero_q && rnd[SigW] && exp_q == ExpMax)) begin
          data_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
          status_d = 4'b0110;
        end else if (unf_q) begin
          data_d   = '0;
          status_d = 4'b1010;
        end else if (zero_q) begin
          data_d   = '0;
          status_d = 4'b0001;
        end else begin
          if (rnd[SigW]) data_d = {sign_q, exp_q + ExpOne, rnd[FRAC_W:1]};
          else           data_d = {sign_q, exp_q, rnd[FRAC_W-1:0]};
          status_d = inexact ? 4'b0010 : 4'b0001;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sign_l_q <= 1'b0;
      sign_s_q <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_l_q  <= '0;
      sig_s_q  <= '0;
      mag_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      zero_q   <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_l_q <= sign_l_d;
      sign_s_q <= sign_s_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_l_q  <= sig_l_d;
      sig_s_q  <= sig_s_d;
      mag_q    <= mag_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      zero_q   <= zero_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed-vector scoreboard bench for fpu_addsub_param at default parameters.
module tb_fpu_addsub_param;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, sub, out_valid, out_ready, busy;
  logic [31:0] op_a, op_b, data_out;
  logic [3:0]  status_out;

  fpu_addsub_param dut (
    .clock100KHz(clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .status_out (status_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_seen = 0;
  int   first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Latency of the iterative build; the LZC build is always 5.
  function automatic int lat_exp(input int iter);
`ifdef FPU_LZC_NORM_EN
    return (iter < 0) ? -1 : 5;
`else
    return iter;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      lat_seen = 0;
    end else begin
      if (out_valid && !lat_seen) begin
        lat_seen  = 1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%08h with no pending operation", data_out);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, data_out, e.d);
          check({e.name, "_status"}, {28'd0, status_out}, {28'd0, e.s});
          if (e.lat >= 0) check({e.name, "_latency"}, first_cyc - e.issue, e.lat);
        end
        lat_seen = 0;
      end
    end
  end

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] d, input logic [3:0] st,
                       input int lat, input bit push);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_in_ready_timeout: in_ready=%0b, required 1", name, in_ready);
    end
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    e.name = name; e.d = d; e.s = st; e.lat = lat; e.issue = cyc;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d0;
    logic [3:0]  s0;
    int          n;
    bit          saw;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sub       = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", data_out, 32'h0);
    check("rst_status", {28'd0, status_out}, 32'h0);
    reset = 1'b0;

    issue("one_plus_one", 32'h40000000, 32'h40000000, 1'b0, 32'h42000000, 4'b0001, lat_exp(6), 1);
    issue("cancel",       32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 4'b0001, lat_exp(5), 1);
    issue("tie_even",     32'h40000000, 32'h0C000000, 1'b0, 32'h40000000, 4'b0010, lat_exp(5), 1);
    issue("above_half",   32'h40000000, 32'h0D000000, 1'b0, 32'h40000001, 4'b0010, lat_exp(5), 1);
    issue("overflow",     32'h7E000000, 32'h7E000000, 1'b0, 32'h7FFFFFFF, 4'b0110, -1, 1);
    issue("underflow",    32'h02000001, 32'h02000000, 1'b1, 32'h00000000, 4'b1010, -1, 1);
    issue("sub_norm",     32'h40000000, 32'h3E000000, 1'b1, 32'h3E000000, 4'b0001, lat_exp(6), 1);
    issue("sub_neg",      32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'b0001, lat_exp(6), 1);
    issue("zero_zero",    32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0001, lat_exp(5), 1);
    issue("neg_add",      32'hC0000000, 32'hC0000000, 1'b0, 32'hC2000000, 4'b0001, lat_exp(6), 1);
    issue("round_carry",  32'h41FFFFFF, 32'h0D000000, 1'b0, 32'h42000000, 4'b0010, lat_exp(5), 1);
    issue("far_sticky",   32'h40000000, 32'h02000000, 1'b0, 32'h40000000, 4'b0010, lat_exp(5), 1);
    issue("sub_sticky",   32'h40000000, 32'h02000000, 1'b1, 32'h40000000, 4'b0010, lat_exp(6), 1);

    // Back-pressure: result must hold while out_ready is low.
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    issue("hold", 32'h40000000, 32'h0D000000, 1'b0, 32'h40000001, 4'b0010, -1, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    d0 = data_out;
    s0 = status_out;
    check("hold_data_value", d0, 32'h40000001);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_data_stable", data_out, d0);
      check("hold_status_stable", {28'd0, status_out}, {28'd0, s0});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;

    // Reset while in OPERATE: no result may emerge.
    issue("rst_mid", 32'h40000000, 32'h40000000, 1'b0, 32'h0, 4'b0, -1, 0);
    @(posedge clk); #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_data", data_out, 32'h0);
    check("mid_status", {28'd0, status_out}, 32'h0);
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1;
    end
    check("mid_no_result", {31'd0, saw}, 32'd0);

    issue("post_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h42000000, 4'b0001, lat_exp(6), 1);
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_param.md
Name: fpu_addsub_param

Overview:
- Parametrised successor of the team's 32-bit sign/exponent/fraction adder.
- Performs add or subtract on two operands in a configurable custom float format {sign, exp[EXP_W], frac[FRAC_W]}.
- Uses valid/ready handshakes on input and output, and rounds round-to-nearest-even with guard/round/sticky bits.
- Sits between the operand register file and the result/status writeback path.

Parameters:
- EXP_W, 6: exponent width. Exponent is an unsigned raw field with no bias arithmetic.
- FRAC_W, 25: stored fraction width. Hidden 1 is implied.
- W, 1+EXP_W+FRAC_W: operand width (derived localparam, 32 at defaults).

Ports:
- clock100KHz  in  1  single clock; all logic rises on its posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- sub  in  1  0 = A+B, 1 = A-B (B sign inverted at capture).
- out_valid  out  1  result/status valid.
- out_ready  in  1  consumer accepts result.
- data_out  out  W  result.
- status_out  out  4  bit0 EXACT, bit1 INEXACT, bit2 OVERFLOW, bit3 UNDERFLOW.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clock100KHz. reset is synchronous, active-high, sampled on posedge clock100KHz.
- Reset state: FSM goes to IDLE. in_ready=1, out_valid=0, busy=0, data_out=0, status_out=4'b0000, all internal registers 0.
- Reset mid-operation: the in-flight operation is abandoned and no result is produced.
- Operand decode:
  - exp==0 and frac==0 is zero, with significand 0.
  - Any other encoding has significand {1, frac}.
- FSM states: IDLE -> ALIGN -> OPERATE -> NORMALIZE -> ROUND -> DONE -> IDLE.
- IDLE:
  - The in_valid && in_ready handshake captures op_a, op_b and sub. Next state is ALIGN.
- ALIGN:
  - The larger exponent is taken as result exponent.
  - The smaller operand's significand is extended by 3 bits (guard, round, sticky) and right-shifted by the exponent difference.
  - Bits shifted out are OR-ed into sticky.
  - If the difference is >= FRAC_W+3, the shifted significand becomes 0 and sticky becomes the OR of the whole original significand.
- OPERATE:
  - Same signs: add magnitudes, with 1 carry bit.
  - Different signs: subtract the smaller magnitude from the larger. Sign is taken from the larger; an equal-magnitude tie gives sign 0.
- NORMALIZE (iterative, one step per cycle):
  - Carry set: shift right 1, keep sticky, exp+1.
  - Else hidden bit 0 and significand nonzero: shift left 1, exp-1.
  - Else go to ROUND.
  - Zero significand with zero sticky goes straight to ROUND as exact zero.
- ROUND: RNE.
  - Increment when G && (R||S||lsb).
  - Inexact when G||R||S.
  - A round carry-out renormalises: shift right 1, exp+1.
- Overflow:
  - Condition: exponent would exceed 2^EXP_W-1 in NORMALIZE or ROUND.
  - Result saturates to {sign, all-ones exp, all-ones frac}.
  - Status is OVERFLOW|INEXACT.
- Underflow:
  - Condition: NORMALIZE needs a left shift while exp==0, or a nonzero result would need exp<0.
  - Result is flushed to +0.
  - Status is UNDERFLOW|INEXACT.
- Exact zero: a zero result (including cancellation) outputs all-zeros with status EXACT.
- EXACT: set only if no other status bit is set, so status_out is never 0 while out_valid=1.
- DONE:
  - out_valid=1. data_out and status_out are held stable until out_valid && out_ready.
  - On that handshake: out_valid=0 next cycle and return to IDLE.
  - data_out and status_out keep their last value after the handshake.
- Latency: 5 + number of normalize shifts, in cycles from the input handshake to out_valid. The minimum is 5 (no normalize shift).
- Throughput: one operation in flight. in_ready is low from capture until the return to IDLE.

Optional Feature:
- Macro: FPU_LZC_NORM_EN.
- Defined: NORMALIZE takes exactly 1 cycle. It uses a leading-zero counter and barrel shift, with the left shift clamped so exp does not drop below 0 (UNDERFLOW rule as above). Latency is fixed at 5 cycles.
- Undefined: iterative 1-bit-per-cycle normalisation as described above.
- Results and status are bit-identical in both builds.

Test Plan:
- 1+1: op_a=0x40000000, op_b=0x40000000, sub=0 -> data_out=0x42000000, status=4'b0001.
- Cancellation: op_a=0x40000000, op_b=0x40000000, sub=1 -> data_out=0x00000000, status=4'b0001.
- Rounding, exact tie: 0x40000000 + 0x0C000000 (half ulp) -> 0x40000000, status=4'b0010 (tie to even).
- Rounding, above half: 0x40000000 + 0x0D000000 -> 0x40000001, status=4'b0010.
- Overflow: 0x7E000000 + 0x7E000000 -> 0x7FFFFFFF, status=4'b0110.
- Underflow: 0x02000001 - 0x02000000 -> 0x00000000, status=4'b1010.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles -> data_out stable, in_ready=0.
  - Assert reset in OPERATE -> next cycle out_valid=0, in_ready=1, data_out=0, status_out=0.
